// File: rtl/cmd_sync_pkg.sv
// Shared types for the synchronisation-block command executor: FSM states,
// the command record, TYPE codes, STATUS bit indices and phase helpers.
package cmd_sync_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_PRE, S_PULSE, S_POST, S_GAP, S_DONE
    } state_t;

    localparam logic [1:0] CMD_CW    = 2'd0;
    localparam logic [1:0] CMD_CHIRP = 2'd1;

    localparam int ST_PARAM_ERR = 0;
    localparam int ST_LATE      = 1;
    localparam int ST_REPLACED  = 2;
    localparam int ST_PEND_OVF  = 3;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] freq_step;
        logic [31:0] freq_rate;
        logic [63:0] time_start;
        logic [15:0] n_imp;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    // Pulse must be non-empty and the three phases must fit in one period.
    function automatic logic cmd_valid(cmd_t c);
        logic [33:0] span;
        span = {2'b00, c.tb1} + {2'b00, c.ti} + {2'b00, c.tb2};
        return (c.ti != 32'd0) && (span <= {2'b00, c.tp});
    endfunction

    // Phase of a period position; zero-length phases fall through naturally.
    function automatic state_t phase_of(cmd_t c, logic [31:0] pc);
        logic [33:0] p, b1, b2, b3;
        p  = {2'b00, pc};
        b1 = {2'b00, c.tb1};
        b2 = b1 + {2'b00, c.ti};
        b3 = b2 + {2'b00, c.tb2};
        if (p < b1)      return S_PRE;
        else if (p < b2) return S_PULSE;
        else if (p < b3) return S_POST;
        else             return S_GAP;
    endfunction

endpackage

// File: rtl/cmd_freq_ramp.sv
// Frequency word generator: load sets the start word, each enabled cycle
// advances a rate counter and adds step when it expires (rate 0 acts as 1).
module cmd_freq_ramp #(
    parameter int FW = 48
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          load,
    input  logic          enable,
    input  logic [FW-1:0] freq_init,
    input  logic [FW-1:0] step,
    input  logic [31:0]   rate,
    output logic [FW-1:0] freq
);

    logic [31:0] rate_cnt;
    logic [31:0] rate_last;

    assign rate_last = (rate == 32'd0) ? 32'd0 : rate - 32'd1;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            freq     <= '0;
            rate_cnt <= '0;
        end else if (load) begin
            freq     <= freq_init;
            rate_cnt <= '0;
        end else if (enable) begin
            if (rate_cnt >= rate_last) begin
                freq     <= freq + step;
                rate_cnt <= '0;
            end else begin
                rate_cnt <= rate_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_exec_sync.sv
// Command executor: arms a command, waits for TIME_START, plays N periods of
// blank/pulse/blank with optional chirp. Define CMD_EXEC_LATE_START_EN to run late commands instead of dropping them.
module cmd_exec_sync
    import cmd_sync_pkg::*;
#(
    parameter int REQ_LEN = 4,
    parameter int FW      = 48
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic [63:0]   TIME,
    input  logic          DATA_WR,
    input  logic [FW-1:0] FREQ_z,
    input  logic [FW-1:0] FREQ_STEP_z,
    input  logic [31:0]   FREQ_RATE_z,
    input  logic [63:0]   TIME_START_z,
    input  logic [15:0]   N_impuls_z,
    input  logic [1:0]    TYPE_impulse_z,
    input  logic [31:0]   Interval_Ti_z,
    input  logic [31:0]   Interval_Tp_z,
    input  logic [31:0]   Tblank1_z,
    input  logic [31:0]   Tblank2_z,
    output logic          REQ_COMM,
    output logic          GATE,
    output logic          BLANK,
    output logic [FW-1:0] FREQ_OUT,
    output logic          BUSY,
    output logic [7:0]    STATUS
);

    cmd_t        cmd_in, cmd_q, cur, cur_nxt, pend, pend_nxt, arm_cmd;
    state_t      st, st_nxt;
    logic        wr_q, pend_full, pend_full_nxt, arm, start;
    logic [31:0] pc, pc_nxt;
    logic [15:0] n_cnt, n_nxt;
    logic [15:0] done_cnt, done_nxt;
    logic [7:0]  status, status_nxt;
    logic        ramp_load, ramp_en;

    assign cmd_in.freq       = FREQ_z;
    assign cmd_in.freq_step  = FREQ_STEP_z;
    assign cmd_in.freq_rate  = FREQ_RATE_z;
    assign cmd_in.time_start = TIME_START_z;
    assign cmd_in.n_imp      = N_impuls_z;
    assign cmd_in.typ        = TYPE_impulse_z;
    assign cmd_in.ti         = Interval_Ti_z;
    assign cmd_in.tp         = Interval_Tp_z;
    assign cmd_in.tb1        = Tblank1_z;
    assign cmd_in.tb2        = Tblank2_z;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            wr_q      <= 1'b0;
            cmd_q     <= '0;
            cur       <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            pc        <= '0;
            n_cnt     <= '0;
            done_cnt  <= '0;
            status    <= '0;
        end else begin
            wr_q      <= DATA_WR;
            if (DATA_WR)
                cmd_q <= cmd_in;
            st        <= st_nxt;
            cur       <= cur_nxt;
            pend      <= pend_nxt;
            pend_full <= pend_full_nxt;
            pc        <= pc_nxt;
            n_cnt     <= n_nxt;
            done_cnt  <= done_nxt;
            status    <= status_nxt;
        end
    end

    always_comb begin
        st_nxt        = st;
        cur_nxt       = cur;
        pend_nxt      = pend;
        pend_full_nxt = pend_full;
        pc_nxt        = pc;
        n_nxt         = n_cnt;
        done_nxt      = done_cnt;
        status_nxt    = status;
        arm           = 1'b0;
        arm_cmd       = cmd_q;
        start         = 1'b0;

        case (st)
            S_IDLE: arm = wr_q;
            S_ARMED: begin
                if (wr_q) begin
                    arm = 1'b1;
                    status_nxt[ST_REPLACED] = 1'b1;
                end else if (TIME >= cur.time_start) begin
                    start = 1'b1;
                end
            end
            S_PRE, S_PULSE, S_POST, S_GAP: begin
                if (wr_q) begin
                    if (pend_full)
                        status_nxt[ST_PEND_OVF] = 1'b1;
                    pend_nxt      = cmd_q;
                    pend_full_nxt = 1'b1;
                end
                if (pc == cur.tp - 32'd1) begin
                    if (n_cnt <= 16'd1) begin
                        st_nxt   = S_DONE;
                        done_nxt = '0;
                    end else begin
                        n_nxt  = n_cnt - 16'd1;
                        pc_nxt = '0;
                        st_nxt = phase_of(cur, 32'd0);
                    end
                end else begin
                    pc_nxt = pc + 32'd1;
                    st_nxt = phase_of(cur, pc + 32'd1);
                end
            end
            S_DONE: begin
                done_nxt = done_cnt + 16'd1;
                // Last DONE cycle keeps REQ_COMM low so a re-entry into DONE
                // always shows the writer a falling edge first.
                if (done_cnt == 16'(REQ_LEN)) begin
                    if (pend_full) begin
                        arm           = 1'b1;
                        arm_cmd       = pend;
                        pend_full_nxt = wr_q;
                        pend_nxt      = wr_q ? cmd_q : pend;
                    end else if (wr_q) begin
                        arm = 1'b1;
                    end else begin
                        st_nxt = S_IDLE;
                    end
                end else if (wr_q) begin
                    if (pend_full)
                        status_nxt[ST_PEND_OVF] = 1'b1;
                    pend_nxt      = cmd_q;
                    pend_full_nxt = 1'b1;
                end
            end
            default: st_nxt = S_IDLE;
        endcase

        if (arm) begin
            cur_nxt = arm_cmd;
            if (!cmd_valid(arm_cmd)) begin
                status_nxt[ST_PARAM_ERR] = 1'b1;
                st_nxt   = S_DONE;
                done_nxt = '0;
            end else if (arm_cmd.time_start <= TIME) begin
                status_nxt[ST_LATE] = 1'b1;
`ifdef CMD_EXEC_LATE_START_EN
                start = 1'b1;
`else
                st_nxt   = S_DONE;
                done_nxt = '0;
`endif
            end else begin
                st_nxt = S_ARMED;
            end
        end

        if (start) begin
            pc_nxt = '0;
            n_nxt  = cur_nxt.n_imp;
            if (cur_nxt.n_imp == 16'd0) begin
                st_nxt   = S_DONE;
                done_nxt = '0;
            end else begin
                st_nxt = phase_of(cur_nxt, 32'd0);
            end
        end
    end

    // Reload on every pulse entry, including back-to-back pulses across periods.
    assign ramp_load = (st_nxt == S_PULSE) && (pc_nxt == cur_nxt.tb1);
    assign ramp_en   = (st == S_PULSE) && (st_nxt == S_PULSE) && (cur.typ == CMD_CHIRP);

    cmd_freq_ramp #(.FW(FW)) u_ramp (
        .CLK       (CLK),
        .rst       (rst),
        .load      (ramp_load),
        .enable    (ramp_en),
        .freq_init (cur_nxt.freq),
        .step      (cur.freq_step),
        .rate      (cur.freq_rate),
        .freq      (FREQ_OUT)
    );

    always_comb begin
        GATE     = (st == S_PULSE);
        BLANK    = (st == S_PRE) || (st == S_POST);
        BUSY     = (st != S_IDLE);
        REQ_COMM = (st == S_DONE) && (done_cnt < 16'(REQ_LEN));
    end

    assign STATUS = status;

endmodule

// File: tb/tb_cmd_exec_sync.sv
// Scoreboard bench for cmd_exec_sync: stimulus queues expected GATE/BLANK/REQ_COMM
// pulses, a negedge monitor measures real pulses and compares them.
module tb_cmd_exec_sync;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] TIME = '0;
    logic        DATA_WR = 1'b0;
    logic [47:0] FREQ_z = '0, FREQ_STEP_z = '0;
    logic [31:0] FREQ_RATE_z = '0;
    logic [63:0] TIME_START_z = '0;
    logic [15:0] N_impuls_z = '0;
    logic [1:0]  TYPE_impulse_z = '0;
    logic [31:0] Interval_Ti_z = '0, Interval_Tp_z = '0, Tblank1_z = '0, Tblank2_z = '0;
    logic        REQ_COMM, GATE, BLANK, BUSY;
    logic [47:0] FREQ_OUT;
    logic [7:0]  STATUS;

    cmd_exec_sync #(.REQ_LEN(4), .FW(48)) dut (
        .CLK(CLK), .rst(rst), .TIME(TIME), .DATA_WR(DATA_WR),
        .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
        .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z), .TYPE_impulse_z(TYPE_impulse_z),
        .Interval_Ti_z(Interval_Ti_z), .Interval_Tp_z(Interval_Tp_z),
        .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
        .REQ_COMM(REQ_COMM), .GATE(GATE), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT),
        .BUSY(BUSY), .STATUS(STATUS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] t;
        int          len;
        logic [47:0] f0;
        logic [47:0] f1;
        logic [7:0]  st;
    } ev_t;

    ev_t gate_q[$], blank_q[$], req_q[$];
    int  checks = 0, errors = 0, req_rises = 0;

    function automatic ev_t mk(input logic [63:0] t, input int len, input logic [47:0] f0,
                               input logic [47:0] f1, input logic [7:0] st);
        ev_t e;
        e.t = t; e.len = len; e.f0 = f0; e.f1 = f1; e.st = st;
        return e;
    endfunction

    function automatic string kname(input int k);
        return (k == 0) ? "gate" : (k == 1) ? "blank" : "req";
    endfunction

    task automatic ev_chk(input int k, input ev_t a);
        ev_t e;
        int  sz;
        checks++;
        sz = (k == 0) ? gate_q.size() : (k == 1) ? blank_q.size() : req_q.size();
        if (sz == 0) begin
            errors++;
            $display("FAIL %s unexpected pulse: t=%0d len=%0d", kname(k), a.t, a.len);
        end else begin
            case (k)
                0:       e = gate_q.pop_front();
                1:       e = blank_q.pop_front();
                default: e = req_q.pop_front();
            endcase
            if (a.t !== e.t || a.len != e.len || a.f0 !== e.f0 || a.f1 !== e.f1 || a.st !== e.st) begin
                errors++;
                $display("FAIL %s pulse: got t=%0d len=%0d f0=%h f1=%h st=%h, expected t=%0d len=%0d f0=%h f1=%h st=%h",
                         kname(k), a.t, a.len, a.f0, a.f1, a.st, e.t, e.len, e.f0, e.f1, e.st);
            end
        end
    endtask

    // Monitor: measure each pulse in TIME units, sampled mid-cycle.
    logic        g_p = 1'b0, b_p = 1'b0, r_p = 1'b0;
    logic [63:0] g_t = '0, b_t = '0, r_t = '0;
    logic [47:0] g_f0 = '0, g_f1 = '0;
    logic [7:0]  r_st = '0;

    always @(negedge CLK) begin
        if (GATE && !g_p) begin g_t = TIME; g_f0 = FREQ_OUT; end
        if (GATE) g_f1 = FREQ_OUT;
        if (!GATE && g_p) ev_chk(0, mk(g_t, int'(TIME - g_t), g_f0, g_f1, 8'h00));
        if (BLANK && !b_p) b_t = TIME;
        if (!BLANK && b_p) ev_chk(1, mk(b_t, int'(TIME - b_t), 48'h0, 48'h0, 8'h00));
        if (REQ_COMM && !r_p) begin r_t = TIME; r_st = STATUS; req_rises++; end
        if (!REQ_COMM && r_p) ev_chk(2, mk(r_t, int'(TIME - r_t), 48'h0, 48'h0, r_st));
        g_p = GATE; b_p = BLANK; r_p = REQ_COMM;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
            TIME = TIME + 64'd1;
        end
    endtask

    task automatic go_to(input logic [63:0] t);
        int guard;
        guard = 0;
        while (TIME < t && guard < 2000) begin
            cyc();
            guard++;
        end
    endtask

    task automatic strobe(input logic [63:0] ts, input logic [15:0] n, input logic [1:0] ty,
                          input logic [47:0] f, input logic [47:0] stp, input logic [31:0] rate,
                          input logic [31:0] ti, input logic [31:0] tp,
                          input logic [31:0] tb1, input logic [31:0] tb2);
        TIME_START_z = ts; N_impuls_z = n; TYPE_impulse_z = ty; FREQ_z = f;
        FREQ_STEP_z = stp; FREQ_RATE_z = rate; Interval_Ti_z = ti; Interval_Tp_z = tp;
        Tblank1_z = tb1; Tblank2_z = tb2;
        DATA_WR = 1'b1;
        cyc();
        DATA_WR = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc();
    endtask

    int rises_before;

    initial begin
        cyc(3);
        check("reset GATE", 64'(GATE), 64'd0);
        check("reset BLANK", 64'(BLANK), 64'd0);
        check("reset REQ_COMM", 64'(REQ_COMM), 64'd0);
        check("reset BUSY", 64'(BUSY), 64'd0);
        check("reset STATUS", 64'(STATUS), 64'd0);
        check("reset FREQ_OUT", 64'(FREQ_OUT), 64'd0);
        rst = 1'b0;
        cyc();

        // Basic CW, two periods
        TIME = 64'd1000;
        blank_q.push_back(mk(1101, 2, 0, 0, 0));
        gate_q.push_back(mk(1103, 10, 48'h1234, 48'h1234, 0));
        blank_q.push_back(mk(1113, 3, 0, 0, 0));
        blank_q.push_back(mk(1141, 2, 0, 0, 0));
        gate_q.push_back(mk(1143, 10, 48'h1234, 48'h1234, 0));
        blank_q.push_back(mk(1153, 3, 0, 0, 0));
        req_q.push_back(mk(1181, 4, 0, 0, 8'h00));
        strobe(1100, 2, 2'd0, 48'h1234, 48'd0, 32'd0, 10, 40, 2, 3);
        go_to(1050);
        check("BUSY while armed", 64'(BUSY), 64'd1);
        go_to(1190);
        check("BUSY after done", 64'(BUSY), 64'd0);

        // Chirp, back-to-back periods without blanks
        TIME = 64'd2000;
        gate_q.push_back(mk(2011, 10, 48'h100, 48'h10F, 0));
        gate_q.push_back(mk(2023, 10, 48'h100, 48'h10F, 0));
        req_q.push_back(mk(2035, 4, 0, 0, 8'h00));
        strobe(2010, 2, 2'd1, 48'h100, 48'd5, 32'd3, 10, 12, 0, 0);
        go_to(2045);

        // 48-bit wrap on the first step
        TIME = 64'd3000;
        gate_q.push_back(mk(3006, 2, 48'hFFFF_FFFF_FFFE, 48'h1, 0));
        req_q.push_back(mk(3008, 4, 0, 0, 8'h00));
        strobe(3005, 1, 2'd1, 48'hFFFF_FFFF_FFFE, 48'd3, 32'd1, 2, 2, 0, 0);
        go_to(3015);

        // N=0: straight to DONE at start time
        TIME = 64'd8000;
        req_q.push_back(mk(8004, 4, 0, 0, 8'h00));
        strobe(8003, 0, 2'd0, 48'h9, 48'd0, 32'd0, 1, 1, 0, 0);
        go_to(8012);

        // Invalid: phases exceed period, then Ti == 0
        TIME = 64'd4000;
        req_q.push_back(mk(4002, 4, 0, 0, 8'h01));
        strobe(4100, 1, 2'd0, 48'h1, 48'd0, 32'd0, 10, 40, 20, 20);
        go_to(4010);
        req_q.push_back(mk(4012, 4, 0, 0, 8'h01));
        strobe(4100, 1, 2'd0, 48'h1, 48'd0, 32'd0, 0, 10, 0, 0);
        go_to(4020);
        do_reset();

        // Replace while armed, then two strobes during PULSE (overflow)
        TIME = 64'd5000;
        blank_q.push_back(mk(5051, 1, 0, 0, 0));
        gate_q.push_back(mk(5052, 4, 48'h42, 48'h42, 0));
        blank_q.push_back(mk(5056, 1, 0, 0, 0));
        req_q.push_back(mk(5059, 4, 0, 0, 8'h0C));
        gate_q.push_back(mk(5071, 3, 48'h77, 48'h77, 0));
        req_q.push_back(mk(5076, 4, 0, 0, 8'h0C));
        strobe(5100, 1, 2'd0, 48'h31, 48'd0, 32'd0, 4, 8, 1, 1);
        cyc();
        strobe(5050, 1, 2'd0, 48'h42, 48'd0, 32'd0, 4, 8, 1, 1);
        go_to(5053);
        strobe(5200, 5, 2'd0, 48'hEE, 48'd0, 32'd0, 7, 9, 1, 1);
        strobe(5070, 1, 2'd0, 48'h77, 48'd0, 32'd0, 3, 5, 0, 0);
        go_to(5085);
        do_reset();

        // Late start
        TIME = 64'd7000;
`ifdef CMD_EXEC_LATE_START_EN
        gate_q.push_back(mk(7002, 2, 48'h5A, 48'h5A, 0));
        blank_q.push_back(mk(7004, 1, 0, 0, 0));
        req_q.push_back(mk(7005, 4, 0, 0, 8'h02));
`else
        req_q.push_back(mk(7002, 4, 0, 0, 8'h02));
`endif
        strobe(6990, 1, 2'd0, 48'h5A, 48'd0, 32'd0, 2, 3, 0, 1);
        go_to(7015);
        do_reset();

        // Reset during PULSE
        TIME = 64'd9000;
        gate_q.push_back(mk(9003, 7, 48'h55, 48'h55, 0));
        strobe(9002, 1, 2'd0, 48'h55, 48'd0, 32'd0, 20, 20, 0, 0);
        go_to(9005);
        strobe(9500, 1, 2'd0, 48'h1, 48'd0, 32'd0, 2, 4, 0, 0);
        strobe(9600, 1, 2'd0, 48'h2, 48'd0, 32'd0, 2, 4, 0, 0);
        go_to(9010);
        check("STATUS overflow before rst", 64'(STATUS), 64'h08);
        rises_before = req_rises;
        #1 rst = 1'b1;
        #1;
        check("GATE async drop", 64'(GATE), 64'd0);
        check("BLANK after rst", 64'(BLANK), 64'd0);
        check("BUSY after rst", 64'(BUSY), 64'd0);
        check("STATUS after rst", 64'(STATUS), 64'd0);
        check("REQ_COMM after rst", 64'(REQ_COMM), 64'd0);
        cyc(2);
        rst = 1'b0;
        go_to(9060);
        check("no REQ_COMM after rst", 64'(req_rises), 64'(rises_before));

        for (int i = 0; i < 200 && (gate_q.size() + blank_q.size() + req_q.size()) > 0; i++)
            cyc();
        check("gate pulses outstanding", 64'(gate_q.size()), 64'd0);
        check("blank pulses outstanding", 64'(blank_q.size()), 64'd0);
        check("req pulses outstanding", 64'(req_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
